// File: rtl/arb_mux_pkg.sv
// ---------------------------------------------------------------------------
// arb_mux_pkg
// Shared constants and helpers for the arbitrated stream multiplexer.
//   MODE_FIXED / MODE_RR : arbitration mode selectors for the Mode parameter
//   clog2()              : ceiling log2, used to size and check index widths
// ---------------------------------------------------------------------------
package arb_mux_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    // Ceiling log2 of a positive integer; clog2(4) = 2, clog2(5) = 3.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// One-hot arbiter over NumInputs requesters, fixed priority or round-robin.
// Ports:
//   clk, reset    : clock and synchronous active-high reset
//   Req           : per-channel request vector
//   Advance       : a grant was accepted this cycle; moves the RR pointer
//   Grant         : one-hot grant (zero when no request)
//   GrantIdx      : binary index of the granted channel
// ---------------------------------------------------------------------------
module rr_arbiter
    import arb_mux_pkg::*;
#(
    parameter int NumInputs = 4,
    parameter int Mode      = MODE_FIXED,
    localparam int IdxWidth = (clog2(NumInputs) < 1) ? 1 : clog2(NumInputs)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NumInputs-1:0] Req,
    input  logic                 Advance,
    output logic [NumInputs-1:0] Grant,
    output logic [IdxWidth-1:0]  GrantIdx
);

    logic [IdxWidth-1:0]  last_q;
    logic [IdxWidth-1:0]  last_d;
    logic [NumInputs-1:0] grant_vec;
    logic [IdxWidth-1:0]  grant_idx;
    logic [IdxWidth-1:0]  idx_sel;
    int                   start;
    int                   idx;

    // Walk the channels once, beginning at the search start and wrapping
    // modulo NumInputs; the first requester found wins. Fixed priority is
    // just a search that always starts at channel 0.
    always_comb begin
        grant_vec = '0;
        grant_idx = '0;
        idx       = 0;
        idx_sel   = '0;
        start     = (Mode == MODE_RR) ? int'(last_q) + 1 : 0;
        for (int k = 0; k < NumInputs; k++) begin
            idx     = (start + k) % NumInputs;
            idx_sel = IdxWidth'(idx);
            if ((grant_vec == '0) && Req[idx_sel]) begin
                grant_vec[idx_sel] = 1'b1;
                grant_idx          = idx_sel;
            end
        end
    end

    // The pointer only moves when the grant is actually taken, so a stalled
    // grant is offered again to the same channel next cycle.
    always_comb begin
        last_d = last_q;
        if (Advance) begin
            last_d = grant_idx;
        end
    end

    // Reset to the highest index so the first search begins at channel 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= IdxWidth'(NumInputs - 1);
        end else begin
            last_q <= last_d;
        end
    end

    assign Grant    = grant_vec;
    assign GrantIdx = grant_idx;

endmodule

// File: rtl/arb_stream_mux.sv
// ---------------------------------------------------------------------------
// arb_stream_mux
// N-input valid/ready stream multiplexer with built-in arbitration and a
// one-entry output register that also reports the source channel.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   InValid    : per-channel request
//   InData     : flattened words, channel i at [i*inputWidth +: inputWidth]
//   InReady    : per-channel accept, one-hot or zero
//   OutValid   : output register holds a word
//   OutData    : registered word
//   OutSel     : channel that supplied OutData
//   OutReady   : consumer takes OutData this cycle
// ---------------------------------------------------------------------------
module arb_stream_mux
    import arb_mux_pkg::*;
#(
    parameter int inputWidth = 32,
    parameter int NumInputs  = 4,
    parameter int SelWidth   = 2,
    parameter int Mode       = MODE_FIXED
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NumInputs-1:0]            InValid,
    input  logic [NumInputs*inputWidth-1:0] InData,
    output logic [NumInputs-1:0]            InReady,
    output logic                            OutValid,
    output logic [inputWidth-1:0]           OutData,
    output logic [SelWidth-1:0]             OutSel,
    input  logic                            OutReady
);

    generate
        if (SelWidth != clog2(NumInputs)) begin : g_bad_sel_width
            $error("arb_stream_mux: SelWidth must equal ceil(log2(NumInputs))");
        end
    endgenerate

    logic [NumInputs-1:0]  grant;
    logic [SelWidth-1:0]   grant_idx;
    logic                  load;
    logic                  transfer;
    logic [NumInputs-1:0]  in_ready;
    logic [inputWidth-1:0] sel_word;

    logic                  out_valid_q, out_valid_d;
    logic [inputWidth-1:0] out_data_q,  out_data_d;
    logic [SelWidth-1:0]   out_sel_q,   out_sel_d;

    rr_arbiter #(
        .NumInputs (NumInputs),
        .Mode      (Mode)
    ) u_arbiter (
        .clk      (clk),
        .reset    (reset),
        .Req      (InValid),
        .Advance  (transfer),
        .Grant    (grant),
        .GrantIdx (grant_idx)
    );

    // The register can take a word when it is empty or being drained this
    // cycle. OutReady reaches InReady combinationally on purpose: that is
    // what sustains one word per cycle. Reset blocks every accept.
    always_comb begin
        load     = ~out_valid_q | OutReady;
        in_ready = grant & {NumInputs{load & ~reset}};
        transfer = |(InValid & in_ready);
    end

    // Slice the granted channel's word out of the flattened bus.
    always_comb begin
        sel_word = '0;
        for (int i = 0; i < NumInputs; i++) begin
            if (grant[i]) begin
                sel_word = InData[i*inputWidth +: inputWidth];
            end
        end
    end

    // A transfer always replaces the held word; a drain without a new word
    // only clears valid, leaving data and index as a record of the last word.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        if (transfer) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_word;
            out_sel_d   = grant_idx;
        end else if (OutReady) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign InReady  = in_ready;
    assign OutValid = out_valid_q;
    assign OutData  = out_data_q;
    assign OutSel   = out_sel_q;

endmodule

// File: tb/tb_arb_stream_mux.sv
// ---------------------------------------------------------------------------
// tb_arb_stream_mux
// Directed bench driving one fixed-priority and one round-robin instance
// of arb_stream_mux from the same stimulus, with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_arb_stream_mux;

    logic         clk;
    logic         reset;
    logic [3:0]   in_valid;
    logic [127:0] in_data;
    logic         out_ready;

    logic [3:0]   fx_in_ready;
    logic         fx_out_valid;
    logic [31:0]  fx_out_data;
    logic [1:0]   fx_out_sel;

    logic [3:0]   rr_in_ready;
    logic         rr_out_valid;
    logic [31:0]  rr_out_data;
    logic [1:0]   rr_out_sel;

    int checks;
    int failures;

    arb_stream_mux #(
        .inputWidth (32),
        .NumInputs  (4),
        .SelWidth   (2),
        .Mode       (0)
    ) dut_fixed (
        .clk      (clk),
        .reset    (reset),
        .InValid  (in_valid),
        .InData   (in_data),
        .InReady  (fx_in_ready),
        .OutValid (fx_out_valid),
        .OutData  (fx_out_data),
        .OutSel   (fx_out_sel),
        .OutReady (out_ready)
    );

    arb_stream_mux #(
        .inputWidth (32),
        .NumInputs  (4),
        .SelWidth   (2),
        .Mode       (1)
    ) dut_rr (
        .clk      (clk),
        .reset    (reset),
        .InValid  (in_valid),
        .InData   (in_data),
        .InReady  (rr_in_ready),
        .OutValid (rr_out_valid),
        .OutData  (rr_out_data),
        .OutSel   (rr_out_sel),
        .OutReady (out_ready)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle just past it before driving/sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic ready);
        in_valid  = valid;
        out_ready = ready;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Linear directed sequence; every step drives just past an edge and
    // checks the combinational accept plus the registered outputs.
    initial begin
        logic [1:0] rr_seq [6];
        rr_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        checks   = 0;
        failures = 0;
        in_data  = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        reset    = 1'b1;
        applyStimulus(4'b1111, 1'b1);

        // Reset held for two cycles with every channel requesting.
        #1;
        checkOutput("rst_rr_ready_c0", 32'(rr_in_ready), 32'h0);
        for (int c = 0; c < 2; c++) begin
            tick();
            checkOutput("rst_rr_ready", 32'(rr_in_ready), 32'h0);
            checkOutput("rst_fx_ready", 32'(fx_in_ready), 32'h0);
            checkOutput("rst_rr_valid", 32'(rr_out_valid), 32'h0);
            checkOutput("rst_fx_valid", 32'(fx_out_valid), 32'h0);
        end
        reset = 1'b0;
        #0;
        checkOutput("post_rst_rr_first", 32'(rr_in_ready), 32'h1);
        checkOutput("post_rst_fx_first", 32'(fx_in_ready), 32'h1);

        // Round-robin streaming: 0,1,2,3,0,1 back to back with no bubbles.
        for (int k = 0; k < 6; k++) begin
            tick();
            checkOutput($sformatf("rr_seq_sel%0d", k), 32'(rr_out_sel), 32'(rr_seq[k]));
            checkOutput($sformatf("rr_seq_data%0d", k), rr_out_data, 32'hA0 + 32'(rr_seq[k]));
            checkOutput($sformatf("rr_seq_valid%0d", k), 32'(rr_out_valid), 32'h1);
            checkOutput($sformatf("fx_seq_sel%0d", k), 32'(fx_out_sel), 32'h0);
        end

        // Fixed priority: channel 1 beats channel 3 until it withdraws.
        applyStimulus(4'b1010, 1'b1);
        #0;
        checkOutput("fx_pri_ready", 32'(fx_in_ready), 32'h2);
        for (int k = 0; k < 2; k++) begin
            tick();
            checkOutput("fx_pri_sel", 32'(fx_out_sel), 32'h1);
            checkOutput("fx_pri_data", fx_out_data, 32'hA1);
            checkOutput("fx_pri_ready_hold", 32'(fx_in_ready), 32'h2);
        end
        applyStimulus(4'b1000, 1'b1);
        #0;
        checkOutput("fx_pri_ch3_ready", 32'(fx_in_ready), 32'h8);
        tick();
        checkOutput("fx_pri_ch3_sel", 32'(fx_out_sel), 32'h3);
        checkOutput("fx_pri_ch3_data", fx_out_data, 32'hA3);
        checkOutput("rr_ch3_sel", 32'(rr_out_sel), 32'h3);

        // Backpressure: full register, consumer stalled three cycles.
        applyStimulus(4'b0100, 1'b0);
        #0;
        checkOutput("bp_rr_ready_c0", 32'(rr_in_ready), 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("bp_rr_ready", 32'(rr_in_ready), 32'h0);
            checkOutput("bp_fx_ready", 32'(fx_in_ready), 32'h0);
            checkOutput("bp_rr_data", rr_out_data, 32'hA3);
            checkOutput("bp_rr_valid", 32'(rr_out_valid), 32'h1);
        end
        applyStimulus(4'b0100, 1'b1);
        #0;
        checkOutput("bp_release_ready", 32'(rr_in_ready), 32'h4);
        tick();
        checkOutput("bp_release_sel", 32'(rr_out_sel), 32'h2);
        checkOutput("bp_release_data", rr_out_data, 32'hA2);

        // Wrap-around: park the pointer at 3, then 0 must beat 3.
        applyStimulus(4'b1000, 1'b1);
        tick();
        checkOutput("wrap_setup_sel", 32'(rr_out_sel), 32'h3);
        applyStimulus(4'b1001, 1'b1);
        #0;
        checkOutput("wrap_ready", 32'(rr_in_ready), 32'h1);
        tick();
        checkOutput("wrap_sel", 32'(rr_out_sel), 32'h0);
        checkOutput("wrap_data", rr_out_data, 32'hA0);

        // Drain with nothing requesting: valid falls, data and index hold.
        applyStimulus(4'b0000, 1'b1);
        tick();
        checkOutput("drain_valid", 32'(rr_out_valid), 32'h0);
        checkOutput("drain_data", rr_out_data, 32'hA0);
        checkOutput("drain_sel", 32'(rr_out_sel), 32'h0);

        // Reset mid-stream discards a held word.
        in_data = {32'hA3, 32'hDEAD, 32'hA1, 32'hA0};
        applyStimulus(4'b0100, 1'b0);
        tick();
        checkOutput("mid_full_data", rr_out_data, 32'hDEAD);
        checkOutput("mid_full_valid", 32'(rr_out_valid), 32'h1);
        reset = 1'b1;
        #0;
        checkOutput("mid_rst_ready", 32'(rr_in_ready), 32'h0);
        tick();
        checkOutput("mid_rst_valid", 32'(rr_out_valid), 32'h0);
        checkOutput("mid_rst_data", rr_out_data, 32'h0);
        checkOutput("mid_rst_sel", 32'(rr_out_sel), 32'h0);
        reset   = 1'b0;
        in_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        applyStimulus(4'b1111, 1'b1);
        #0;
        checkOutput("mid_rst_rr_first", 32'(rr_in_ready), 32'h1);
        tick();
        checkOutput("mid_rst_rr_first_sel", 32'(rr_out_sel), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/arb_stream_mux.md
# arb_stream_mux

N-input, parametrised-width multiplexer with per-input valid/ready handshakes, built-in arbitration and a one-entry output register. It extends the 2:1 select mux used in the datapath to a channel-count-generic, flow-controlled form. It sits wherever several producers share one consumer, for example memory-request sources feeding the single memory port, or write-back sources feeding the register file. It selects a winner each cycle, latches the winner's word, and reports which channel it came from.

## Interface
Parameters:
- inputWidth, default 32: data word width in bits (≥1).
- NumInputs, default 4: number of input channels (≥2).
- SelWidth, default 2: width of the channel index. Must equal ceil(log2(NumInputs)).
- Mode, default 0: 0 = fixed priority (lowest index wins); 1 = round-robin.

Ports:
- clk, in, 1: clock. All state updates on the rising edge.
- reset, in, 1: reset. Synchronous and active-high.
- InValid, in, NumInputs: per-channel request. Bit i belongs to channel i.
- InData, in, NumInputs*inputWidth: flattened words. Channel i occupies [i*inputWidth +: inputWidth].
- InReady, out, NumInputs: per-channel accept. One-hot or zero.
- OutValid, out, 1: the output register holds a word.
- OutData, out, inputWidth: the registered word.
- OutSel, out, SelWidth: index of the channel that supplied OutData.
- OutReady, in, 1: the consumer accepts OutData this cycle.

## Operation
- Output register states:
  - EMPTY when OutValid=0.
  - FULL when OutValid=1.
- load = ~OutValid | OutReady. This is the combinational path from OutReady to InReady; it is intentional and gives 1 word/cycle throughput.
- Arbitration is evaluated every cycle over InValid.
  - grant is one-hot among the asserted InValid bits, or zero if none are asserted.
  - InReady = grant & {NumInputs{load}}.
- A transfer on channel i occurs when InValid[i] & InReady[i].
  - On the next edge: OutData ← channel i word, OutSel ← i, OutValid ← 1.
- FULL with OutReady=1 and no new transfer: OutValid ← 0. OutData and OutSel hold their last values.
- FULL with OutReady=0: all outputs hold, and InReady = 0.
- Mode 0: the lowest asserted index always wins. Starvation is permitted.
- Mode 1 (round-robin):
  - The pointer Last holds the last granted index.
  - The search begins at Last+1 and wraps modulo NumInputs, so index NumInputs-1 wraps to 0.
  - Last updates to i only on a completed transfer. A grant that is not accepted (load=0) does not move the pointer.
- Source rule: a channel keeps InValid and its data stable until it sees InReady. Deasserting early is a protocol violation; the block need not detect it.
- Reset values:
  - OutValid=0, OutData=0, OutSel=0.
  - Last=NumInputs-1, so the first round-robin search starts at 0.
  - InReady becomes 1-hot again only after reset deasserts, because load=1 when EMPTY.
- Reset asserted mid-operation discards any held word. No InReady is asserted during reset.

## Timing
- Latency: a transfer in cycle t produces OutValid=1 and the corresponding OutData/OutSel in cycle t+1.
- Throughput: one word per cycle while OutReady=1 and any InValid is asserted.
- Simultaneous events:
  - OutReady=1 together with a new transfer replaces the word in the same edge; OutValid stays 1.
  - If the consumer drains and no channel is valid, OutValid falls to 0 next cycle.
- Mode 1 fairness: a continuously valid channel waits at most NumInputs-1 transfers before it is granted.

## Structure
- Shared package arb_mux_pkg holds:
  - MODE_FIXED=0 and MODE_RR=1 constants.
  - The clog2 helper function used to check SelWidth.
- Sub-module rr_arbiter (parameters NumInputs, Mode):
  - Inputs clk, reset, Req, Advance.
  - Outputs one-hot Grant and GrantIdx.
  - Owns the Last pointer.
- The top level instantiates rr_arbiter and contains the output register and the flattened-data slice select.

## Test plan
- Reset test: drive reset=1 for 2 cycles with InValid=4'b1111. Required: InReady=0 and OutValid=0 throughout. After release, Mode 1 grants channel 0 first.
- Round-robin test: Mode 1, InValid=4'b1111, OutReady=1, channel i data = 32'hA0+i. Required OutSel sequence: 0,1,2,3,0,1. The stream must have no bubbles and matching OutData.
- Fixed-priority test: Mode 0, InValid=4'b1010. Required: channel 1 wins every cycle and InReady=4'b0010 until InValid[1] drops. Channel 3 is then granted the next cycle.
- Backpressure test: OutValid=1 with OutReady=0 for 3 cycles and InValid=4'b0100. Required: InReady=0, OutData held, and Last unchanged. On OutReady=1, channel 2 transfers in the same cycle.
- Wrap-around and drain test: Mode 1 with Last=3 and InValid=4'b1001. Required: channel 0 is granted. Then drop all InValid with OutReady=1; OutValid=0 the next cycle with OutData held.
- Reset mid-stream test: assert reset while FULL with OutData=32'hDEAD. Required: OutValid=0, OutData=0 and OutSel=0 next cycle.
